// File: rtl/dcache_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_mem_responder                                          |
// | Purpose  : Bridges data-cache requests onto a synchronous single-port    |
// |            SRAM. It does single-word writes with byte strobes, and       |
// |            single-word or wrapping critical-word-first burst reads.      |
// | Ports    : clk, rst (async, active-low)                                  |
// |            D_req/D_write/D_strobe/D_addr/D_in/D_type/D_burst : request   |
// |            D_out/D_wait/D_valid                              : response  |
// |            SRAM_CS/SRAM_WEB/SRAM_A/SRAM_DI/SRAM_DO           : SRAM side |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dcache_mem_responder #(
  parameter int SRAM_AW   = 14,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               D_req,
  input  logic               D_write,
  input  logic [3:0]         D_strobe,
  input  logic [31:0]        D_addr,
  input  logic [31:0]        D_in,
  input  logic [2:0]         D_type,
  input  logic               D_burst,
  output logic [31:0]        D_out,
  output logic               D_wait,
  output logic               D_valid,
  output logic               SRAM_CS,
  output logic [3:0]         SRAM_WEB,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic [31:0]        SRAM_DI,
  input  logic [31:0]        SRAM_DO
);

  // Width of the beat counter and of the wrapping word-offset field.
  localparam int c_BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_LAST = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_BW-1:0]      r_beat;
  logic [3:0]           r_strobe;
  logic                 r_burst;
  logic [SRAM_AW-1:0]   r_sram_a;
  logic [31:0]          r_sram_di;
  logic                 r_valid;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_last_beat;
  logic                 w_cs;
  logic [3:0]           w_web;

  // Size field and out-of-window / sub-word address bits carry no meaning here.
  logic w_unused_bits;
  assign w_unused_bits = ^{D_type, D_addr[31:SRAM_AW+2], D_addr[1:0]};

  assign w_last_beat = !r_burst || (r_beat == c_BW'(BURST_LEN - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and SRAM control decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_cs        = 1'b0;
    w_web       = 4'hF;
    case (r_state)
      IDLE: begin
        if (D_req) begin
          w_accept    = 1'b1;
          w_state_nxt = D_write ? WR : RD;
        end
      end
      WR: begin
        w_cs        = 1'b1;
        w_web       = ~r_strobe;
        w_state_nxt = IDLE;
      end
      RD: begin
        w_cs    = 1'b1;
        w_issue = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = RD_LAST;
        end
      end
      RD_LAST: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, burst address sequencing and read-valid tracking.
  // SRAM_A and SRAM_DI are registers so they hold their last values while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat    <= '0;
      r_strobe  <= '0;
      r_burst   <= 1'b0;
      r_sram_a  <= '0;
      r_sram_di <= '0;
      r_valid   <= 1'b0;
    end else begin
      // SRAM data returns one cycle after each address cycle.
      r_valid <= w_issue;
      if (w_accept) begin
        r_strobe <= D_strobe;
        r_burst  <= D_burst & ~D_write;
        r_beat   <= '0;
        r_sram_a <= D_addr[SRAM_AW+1:2];
        if (D_write) begin
          r_sram_di <= D_in;
        end
      end else if (w_issue && !w_last_beat) begin
        r_beat <= r_beat + c_BW'(1);
        // Only the in-burst offset advances, so it wraps within the aligned block.
        r_sram_a[c_BW-1:0] <= r_sram_a[c_BW-1:0] + c_BW'(1);
      end
    end
  end

  assign D_wait   = (r_state != IDLE);
  assign D_valid  = r_valid;
  assign D_out    = r_valid ? SRAM_DO : 32'h0;
  assign SRAM_CS  = w_cs;
  assign SRAM_WEB = w_web;
  assign SRAM_A   = r_sram_a;
  assign SRAM_DI  = r_sram_di;

endmodule
`default_nettype wire
